// File: rtl/ioctl_rom_loader.sv
// Splits 16-bit HPS download words into two byte writes across four ROM regions and captures DIP bytes (index 254).
// Latency: low byte on the bus 1 cycle after ioctl_wr, high byte 1 cycle later; ioctl_wait covers both bytes.
// Backpressure: rom_ready low holds the current byte and stretches ioctl_wait. Optional checksum: LOADER_CHECKSUM_EN.
module ioctl_rom_loader #(
  parameter int          ADDR_W       = 16,
  parameter logic [26:0] REGION1_BASE = 27'h08000,
  parameter logic [26:0] REGION2_BASE = 27'h10000,
  parameter logic [26:0] REGION3_BASE = 27'h18000,
  parameter logic [26:0] REGION_END   = 27'h20000
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [26:0]       ioctl_addr,
  input  logic [15:0]       ioctl_dout,
  output logic              ioctl_wait,
  output logic [3:0]        rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [7:0]        rom_data,
  input  logic              rom_ready,
  output logic [7:0]        dsw,
  output logic [7:0]        p3,
  output logic              done,
  output logic              overrun,
  output logic [7:0]        checksum
);

  typedef enum logic [1:0] {IDLE, LO, HI, FLUSH} state_t;

  typedef struct packed {
    logic [3:0]        we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } beat_t;

  // Out-of-range addresses produce we=0, which the FSM treats as an instant accept.
  function automatic beat_t decode(input logic [26:0] a, input logic [7:0] d);
    beat_t       b;
    logic [26:0] base;
    logic [26:0] rel;
    b.we = 4'b0000;
    base = '0;
    if (a < REGION1_BASE) begin
      b.we = 4'b0001;
    end else if (a < REGION2_BASE) begin
      b.we = 4'b0010;
      base = REGION1_BASE;
    end else if (a < REGION3_BASE) begin
      b.we = 4'b0100;
      base = REGION2_BASE;
    end else if (a < REGION_END) begin
      b.we = 4'b1000;
      base = REGION3_BASE;
    end
    rel    = a - base;
    b.addr = rel[ADDR_W-1:0];
    b.data = d;
    return b;
  endfunction

  state_t      state, state_nx;
  beat_t       beat, beat_nx;
  logic        wait_nx, done_nx;
  logic [26:0] lat_addr;
  logic [7:0]  lat_hi;
  logic        dl_d, pend;
  logic        rom_start, dip_wr, dl_rise, dl_fall, accept, busy;

  assign rom_start = ioctl_wr & ioctl_download & (ioctl_index == 8'd0);
  assign dip_wr    = ioctl_wr & (ioctl_index == 8'd254) & (ioctl_addr[24:3] == 22'd0);
  assign dl_rise   = ioctl_download & ~dl_d & (ioctl_index == 8'd0);
  assign dl_fall   = ~ioctl_download & dl_d & (ioctl_index == 8'd0);
  assign accept    = (beat.we == 4'b0000) | rom_ready;
  assign busy      = (state == LO) | (state == HI);

  assign rom_we   = beat.we;
  assign rom_addr = beat.addr;
  assign rom_data = beat.data;

  always_comb begin
    state_nx = state;
    beat_nx  = '0;
    wait_nx  = 1'b0;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (rom_start) begin
          state_nx = LO;
          wait_nx  = 1'b1;
          beat_nx  = decode(ioctl_addr, ioctl_dout[7:0]);
        end else if (pend) begin
          state_nx = FLUSH;
          done_nx  = 1'b1;
        end
      end
      LO: begin
        wait_nx = 1'b1;
        if (accept) begin
          state_nx = HI;
          beat_nx  = decode(lat_addr + 27'd1, lat_hi);
        end else begin
          beat_nx = beat;
        end
      end
      HI: begin
        if (accept) begin
          state_nx = IDLE;
        end else begin
          wait_nx = 1'b1;
          beat_nx = beat;
        end
      end
      FLUSH:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      beat       <= '0;
      ioctl_wait <= 1'b0;
      done       <= 1'b0;
      lat_addr   <= '0;
      lat_hi     <= '0;
      dl_d       <= 1'b0;
      pend       <= 1'b0;
      overrun    <= 1'b0;
      dsw        <= 8'hFF;
      p3         <= 8'hFF;
    end else begin
      state      <= state_nx;
      beat       <= beat_nx;
      ioctl_wait <= wait_nx;
      done       <= done_nx;
      dl_d       <= ioctl_download;
      if (state == IDLE && rom_start) begin
        lat_addr <= ioctl_addr;
        lat_hi   <= ioctl_dout[15:8];
      end
      // A download end seen while bytes drain is held until the FSM is idle.
      if (dl_fall) pend <= 1'b1;
      else if (state == IDLE && state_nx == FLUSH) pend <= 1'b0;
      if (ioctl_wr && busy) overrun <= 1'b1;
      else if (dl_rise) overrun <= 1'b0;
      if (state == IDLE && dip_wr) begin
        if (ioctl_addr[2:0] == 3'd0) dsw <= ioctl_dout[7:0];
        else if (ioctl_addr[2:0] == 3'd1) p3 <= ioctl_dout[7:0];
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) csum <= 8'h00;
    else if (dl_rise) csum <= 8'h00;
    else if (beat.we != 4'b0000 && rom_ready) csum <= csum + beat.data;
  end
  assign checksum = csum;
`else
  assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_ioctl_rom_loader.sv
// Directed bench for ioctl_rom_loader: byte-queue reference model checked every cycle plus literal spot checks.
module tb_ioctl_rom_loader;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [26:0] ioctl_addr = '0;
  logic [15:0] ioctl_dout = '0;
  logic        rom_ready = 1'b1;
  logic        ioctl_wait, done, overrun;
  logic [3:0]  rom_we;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data, dsw, p3, checksum;

  ioctl_rom_loader dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .rom_we(rom_we),
    .rom_addr(rom_addr), .rom_data(rom_data), .rom_ready(rom_ready),
    .dsw(dsw), .p3(p3), .done(done), .overrun(overrun), .checksum(checksum)
  );

  always #5 clk_sys = ~clk_sys;

  int total = 0;
  int bad = 0;
  int wait_cnt = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted word becomes two queued bytes; the queue head is what must be on the bus.
  typedef struct {
    logic [3:0]  we;
    logic [15:0] a;
    logic [7:0]  d;
  } mbeat_t;

  mbeat_t     q[$];
  logic [7:0] m_dsw = 8'hFF, m_p3 = 8'hFF, m_sum = 8'h00;
  bit         m_over = 0, m_pend = 0, m_flush = 0, m_dl = 0;
  bit         m_busy, m_idle, m_rise, m_fall, m_sf;

  // Regions are four consecutive 32 KiB windows; anything past them is discarded.
  function automatic mbeat_t mk(input logic [26:0] a, input logic [7:0] d);
    mbeat_t b;
    int     r;
    r    = int'(a) / 32768;
    b.we = (r < 4) ? 4'(1 << r) : 4'b0000;
    b.a  = 16'(int'(a) % 32768);
    b.d  = d;
    return b;
  endfunction

  always @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      q.delete();
      m_dsw = 8'hFF; m_p3 = 8'hFF; m_sum = 8'h00;
      m_over = 0; m_pend = 0; m_flush = 0; m_dl = 0;
    end else begin
      m_busy = (q.size() != 0);
      m_idle = !m_busy && !m_flush;
      m_rise = ioctl_download && !m_dl && ioctl_index == 8'd0;
      m_fall = !ioctl_download && m_dl && ioctl_index == 8'd0;
      m_sf   = 0;
      if (m_busy) begin
        if (q[0].we == 4'b0000 || rom_ready) begin
`ifdef LOADER_CHECKSUM_EN
          if (q[0].we != 4'b0000) m_sum = m_sum + q[0].d;
`endif
          void'(q.pop_front());
        end
        if (ioctl_wr) m_over = 1;
      end else if (m_flush) begin
        m_flush = 0;
      end else if (ioctl_wr && ioctl_download && ioctl_index == 8'd0) begin
        q.push_back(mk(ioctl_addr, ioctl_dout[7:0]));
        q.push_back(mk(ioctl_addr + 27'd1, ioctl_dout[15:8]));
      end else if (m_pend) begin
        m_flush = 1;
        m_sf    = 1;
      end
      if (m_idle && ioctl_wr && ioctl_index == 8'd254 && ioctl_addr[24:3] == 22'd0) begin
        if (ioctl_addr[2:0] == 3'd0) m_dsw = ioctl_dout[7:0];
        if (ioctl_addr[2:0] == 3'd1) m_p3 = ioctl_dout[7:0];
      end
      if (m_rise) begin
        if (!(m_busy && ioctl_wr)) m_over = 0;
        m_sum = 8'h00;
      end
      m_pend = m_fall ? 1'b1 : (m_sf ? 1'b0 : m_pend);
      m_dl   = ioctl_download;
    end
  end

  always @(negedge clk_sys) begin
    if (!reset) begin
      if (ioctl_wait) wait_cnt++;
      if (done) done_cnt++;
      chk("wait", 32'(ioctl_wait), 32'(q.size() != 0));
      chk("rom_we", 32'(rom_we), 32'(q.size() != 0 ? q[0].we : 4'b0000));
      if (q.size() != 0 && q[0].we != 4'b0000) begin
        chk("rom_addr", 32'(rom_addr), 32'(q[0].a));
        chk("rom_data", 32'(rom_data), 32'(q[0].d));
      end
      chk("dsw", 32'(dsw), 32'(m_dsw));
      chk("p3", 32'(p3), 32'(m_p3));
      chk("done", 32'(done), 32'(m_flush));
      chk("overrun", 32'(overrun), 32'(m_over));
      chk("checksum", 32'(checksum), 32'(m_sum));
    end
  end

  task automatic write_word(input logic [7:0] idx, input logic [26:0] a, input logic [15:0] d);
    ioctl_index = idx;
    ioctl_addr  = a;
    ioctl_dout  = d;
    ioctl_wr    = 1'b1;
    @(posedge clk_sys);
    #1 ioctl_wr = 1'b0;
  endtask

  logic [7:0] cs1, cs2;

  initial begin
`ifdef LOADER_CHECKSUM_EN
    cs1 = 8'hFF;
    cs2 = 8'hD1;
`else
    cs1 = 8'h00;
    cs2 = 8'h00;
`endif
    repeat (2) @(posedge clk_sys);
    #1;
    chk("rst_wait", 32'(ioctl_wait), 0);
    chk("rst_we", 32'(rom_we), 0);
    chk("rst_dsw", 32'(dsw), 32'hFF);
    chk("rst_p3", 32'(p3), 32'hFF);
    reset = 1'b0;
    ioctl_download = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;

    // Region 0 word, sink always ready.
    wait_cnt = 0;
    write_word(8'd0, 27'h0, 16'hA55A);
    chk("t1_we_lo", 32'(rom_we), 32'h1);
    chk("t1_addr_lo", 32'(rom_addr), 0);
    chk("t1_data_lo", 32'(rom_data), 32'h5A);
    @(posedge clk_sys); #1;
    chk("t1_addr_hi", 32'(rom_addr), 1);
    chk("t1_data_hi", 32'(rom_data), 32'hA5);
    @(posedge clk_sys); #1;
    chk("t1_wait_end", 32'(ioctl_wait), 0);
    chk("t1_wait_cycles", 32'(wait_cnt), 2);
    chk("t1_checksum", 32'(checksum), 32'(cs1));

    // Region 2 word with a 3-cycle sink stall on the low byte.
    wait_cnt = 0;
    rom_ready = 1'b0;
    write_word(8'd0, 27'h10004, 16'h3C96);
    chk("t2_we", 32'(rom_we), 32'h4);
    chk("t2_addr", 32'(rom_addr), 4);
    repeat (3) @(posedge clk_sys);
    #1 rom_ready = 1'b1;
    chk("t2_data_held", 32'(rom_data), 32'h96);
    repeat (3) @(posedge clk_sys); #1;
    chk("t2_wait_cycles", 32'(wait_cnt), 5);
    chk("t2_checksum", 32'(checksum), 32'(cs2));

    // Out-of-range word is discarded without stalling.
    wait_cnt = 0;
    write_word(8'd0, 27'h20000, 16'h1234);
    chk("t3_we", 32'(rom_we), 0);
    repeat (2) @(posedge clk_sys); #1;
    chk("t3_wait_cycles", 32'(wait_cnt), 2);
    chk("t3_checksum", 32'(checksum), 32'(cs2));

    // Region boundaries, checked by the per-cycle model.
    write_word(8'd0, 27'h07FFE, 16'h0201);
    repeat (2) @(posedge clk_sys); #1;
    write_word(8'd0, 27'h08000, 16'h0403);
    repeat (2) @(posedge clk_sys); #1;
    write_word(8'd0, 27'h17FFE, 16'h0605);
    repeat (2) @(posedge clk_sys); #1;
    write_word(8'd0, 27'h1FFFE, 16'h0807);
    repeat (2) @(posedge clk_sys); #1;

    // DIP capture.
    write_word(8'd254, 27'h0, 16'h00C3);
    chk("dip_dsw", 32'(dsw), 32'hC3);
    write_word(8'd254, 27'h1, 16'h0012);
    chk("dip_p3", 32'(p3), 32'h12);
    write_word(8'd254, 27'h8, 16'h0055);
    write_word(8'd254, 27'h2, 16'h0077);
    chk("dip_dsw_keep", 32'(dsw), 32'hC3);
    chk("dip_p3_keep", 32'(p3), 32'h12);

    // Second strobe during the high byte is dropped and flagged.
    write_word(8'd0, 27'h100, 16'hBEEF);
    @(posedge clk_sys); #1;
    ioctl_addr = 27'h102;
    ioctl_dout = 16'hDEAD;
    ioctl_wr   = 1'b1;
    @(posedge clk_sys); #1 ioctl_wr = 1'b0;
    chk("ovr_set", 32'(overrun), 1);
    repeat (2) @(posedge clk_sys); #1;
    ioctl_download = 1'b0;
    repeat (4) @(posedge clk_sys); #1;
    ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
    chk("ovr_clear", 32'(overrun), 0);
    repeat (2) @(posedge clk_sys); #1;

    // Download ends while the high byte is on the bus.
    done_cnt = 0;
    write_word(8'd0, 27'h200, 16'h7788);
    @(posedge clk_sys); #1;
    ioctl_download = 1'b0;
    @(posedge clk_sys); #1;
    chk("done_early", 32'(done), 0);
    @(posedge clk_sys); #1;
    chk("done_pulse", 32'(done), 1);
    repeat (4) @(posedge clk_sys); #1;
    chk("done_once", 32'(done_cnt), 1);
    ioctl_download = 1'b1;
    @(posedge clk_sys); #1;

    // Asynchronous reset in the middle of a word.
    write_word(8'd0, 27'h300, 16'hCAFE);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_we", 32'(rom_we), 0);
    chk("mid_rst_wait", 32'(ioctl_wait), 0);
    chk("mid_rst_addr", 32'(rom_addr), 0);
    chk("mid_rst_data", 32'(rom_data), 0);
    chk("mid_rst_dsw", 32'(dsw), 32'hFF);
    chk("mid_rst_p3", 32'(p3), 32'hFF);
    chk("mid_rst_cs", 32'(checksum), 0);
    @(posedge clk_sys); #1 reset = 1'b0;
    repeat (4) @(posedge clk_sys); #1;
    chk("post_rst_we", 32'(rom_we), 0);
    chk("post_rst_wait", 32'(ioctl_wait), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
